// File: rtl/i2c_slave.sv
//------------------------------------------------------------------------------
// i2c_slave
//
// Write-only I2C slave (optionally readable) exposing three 8-bit control
// registers for a waveform generator:
//    0x00 wave        waveform select
//    0x01 frequency   frequency setting
//    0x02 duty_cycle  duty-cycle setting
//
// A write transaction is: START, address byte (SLAVE_ADDR, R/W=0), register
// pointer byte, then any number of data bytes.  Each data byte lands in the
// pointed register and the pointer advances 0 -> 1 -> 2 -> 0.
//
// scl and sda are oversampled by clk (clk must run at least 10x the SCL rate)
// through two-flop synchronisers; all bus events are derived from the
// synchronised copies.
//
// Optional feature macro: I2C_SLAVE_READ_EN
//    undefined : a read address (R/W=1) is NACKed, the slave goes quiet
//    defined   : reads are ACKed and the pointed registers are shifted out
//
// Ports:
//    clk         system clock, rising-edge logic
//    reset       asynchronous active-low reset
//    scl         I2C clock from the master (input only)
//    sda         I2C data, open drain; this block drives only 0 or z
//    wave        register 0x00
//    frequency   register 0x01
//    duty_cycle  register 0x02
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module i2c_slave #(
   parameter logic [6:0] SLAVE_ADDR = 7'h55
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       scl,
   inout  wire        sda,
   output logic [7:0] wave,
   output logic [7:0] frequency,
   output logic [7:0] duty_cycle
);

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      REG,
      REG_ACK,
      DATA,
      DATA_ACK,
      WAIT_STOP,
      READ,
      READ_ACK
   } state_t;

   state_t      state;
   state_t      next_state;

   logic        scl_meta;
   logic        scl_sync;
   logic        scl_prev;
   logic        sda_meta;
   logic        sda_sync;
   logic        sda_prev;

   logic        scl_rise;
   logic        scl_fall;
   logic        start_det;
   logic        stop_det;

   logic [3:0]  bit_cnt;
   logic [7:0]  shift_reg;
   logic [7:0]  byte_in;
   logic        byte_full;
   logic        ack;
   logic [1:0]  ptr;
   logic [1:0]  next_ptr;
   logic        sda_low;

`ifdef I2C_SLAVE_READ_EN
   logic        rw_bit;
   logic [7:0]  rd_cur;
   logic [7:0]  rd_next;
`endif

   // Open-drain output: either pull the line low or let the pull-up win.
   assign sda = sda_low ? 1'b0 : 1'bz;

   // Two-flop synchronisers plus one extra history flop for edge detection.
   // They reset to 1 (the idle bus level) so leaving reset never looks like
   // a START or STOP.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         scl_meta <= 1'b1;
         scl_sync <= 1'b1;
         scl_prev <= 1'b1;
         sda_meta <= 1'b1;
         sda_sync <= 1'b1;
         sda_prev <= 1'b1;
      end else begin
         scl_meta <= scl;
         scl_sync <= scl_meta;
         scl_prev <= scl_sync;
         sda_meta <= sda;
         sda_sync <= sda_meta;
         sda_prev <= sda_sync;
      end
   end

   // START/STOP are sda edges while scl has been high for two samples, which
   // keeps ordinary data changes (made while scl is low) from qualifying.
   assign scl_rise  = scl_sync & ~scl_prev;
   assign scl_fall  = ~scl_sync & scl_prev;
   assign start_det = scl_sync & scl_prev & sda_prev & ~sda_sync;
   assign stop_det  = scl_sync & scl_prev & ~sda_prev & sda_sync;

   // The byte as it will look once the bit being sampled now is shifted in.
   assign byte_in   = {shift_reg[6:0], sda_sync};
   assign byte_full = (bit_cnt == 4'd8);
   assign next_ptr  = (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;

`ifdef I2C_SLAVE_READ_EN
   function automatic logic [7:0] pick_reg(input logic [1:0] sel,
                                           input logic [7:0] r0,
                                           input logic [7:0] r1,
                                           input logic [7:0] r2);
      case (sel)
         2'd0:    pick_reg = r0;
         2'd1:    pick_reg = r1;
         2'd2:    pick_reg = r2;
         default: pick_reg = 8'h00;
      endcase
   endfunction

   assign rd_cur  = pick_reg(ptr, wave, frequency, duty_cycle);
   assign rd_next = pick_reg(next_ptr, wave, frequency, duty_cycle);
`endif

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic.  START and STOP override everything; otherwise the
   // byte states hand over to their acknowledge state on the 8th scl fall,
   // and the acknowledge states finish on the 9th scl fall.
   always_comb begin
      next_state = state;
      if (start_det) begin
         next_state = ADDR;
      end else if (stop_det) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE:      next_state = IDLE;
            ADDR:      if (scl_fall && byte_full) next_state = ADDR_ACK;
            ADDR_ACK: begin
               if (scl_fall) begin
`ifdef I2C_SLAVE_READ_EN
                  if (!ack)        next_state = WAIT_STOP;
                  else if (rw_bit) next_state = READ;
                  else             next_state = REG;
`else
                  next_state = ack ? REG : WAIT_STOP;
`endif
               end
            end
            REG:       if (scl_fall && byte_full) next_state = REG_ACK;
            REG_ACK:   if (scl_fall) next_state = ack ? DATA : WAIT_STOP;
            DATA:      if (scl_fall && byte_full) next_state = DATA_ACK;
            DATA_ACK:  if (scl_fall) next_state = DATA;
            WAIT_STOP: next_state = WAIT_STOP;
`ifdef I2C_SLAVE_READ_EN
            READ:      if (scl_fall && byte_full) next_state = READ_ACK;
            READ_ACK:  if (scl_fall) next_state = ack ? READ : WAIT_STOP;
`endif
            default:   next_state = IDLE;
         endcase
      end
   end

   // Datapath: bit shifting, ack decisions, pointer and register updates and
   // the sda drive.  Bits are taken on scl rising edges; the sda drive only
   // changes right after an scl falling edge so it is stable while scl is
   // high.  The ack/nack decision is made on the 8th rising edge and put on
   // the bus at the following falling edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bit_cnt    <= 4'd0;
         shift_reg  <= 8'h00;
         ack        <= 1'b0;
         ptr        <= 2'd0;
         sda_low    <= 1'b0;
         wave       <= 8'h00;
         frequency  <= 8'h00;
         duty_cycle <= 8'h00;
`ifdef I2C_SLAVE_READ_EN
         rw_bit     <= 1'b0;
`endif
      end else if (start_det || stop_det) begin
         // A partial byte is simply dropped; registers are untouched.
         bit_cnt <= 4'd0;
         sda_low <= 1'b0;
      end else begin
         case (state)
            ADDR, REG, DATA: begin
               if (scl_rise && !byte_full) begin
                  shift_reg <= byte_in;
                  bit_cnt   <= bit_cnt + 4'd1;
                  if (bit_cnt == 4'd7) begin
                     if (state == ADDR) begin
`ifdef I2C_SLAVE_READ_EN
                        ack    <= (byte_in[7:1] == SLAVE_ADDR);
                        rw_bit <= byte_in[0];
`else
                        ack    <= (byte_in[7:1] == SLAVE_ADDR) && !byte_in[0];
`endif
                     end else if (state == REG) begin
                        ack <= (byte_in <= 8'd2);
                        if (byte_in <= 8'd2) begin
                           ptr <= byte_in[1:0];
                        end
                     end else begin
                        ack <= 1'b1;
                        ptr <= next_ptr;
                        case (ptr)
                           2'd0:    wave       <= byte_in;
                           2'd1:    frequency  <= byte_in;
                           2'd2:    duty_cycle <= byte_in;
                           default: ;
                        endcase
                     end
                  end
               end else if (scl_fall && byte_full) begin
                  sda_low <= ack;
                  bit_cnt <= 4'd0;
               end
            end

            ADDR_ACK, REG_ACK, DATA_ACK: begin
               if (scl_fall) begin
`ifdef I2C_SLAVE_READ_EN
                  // A granted read puts the first data bit out on the same
                  // falling edge that ends the address acknowledge.
                  if (state == ADDR_ACK && ack && rw_bit) begin
                     shift_reg <= rd_cur;
                     sda_low   <= ~rd_cur[7];
                     bit_cnt   <= 4'd0;
                  end else begin
                     sda_low <= 1'b0;
                  end
`else
                  sda_low <= 1'b0;
`endif
               end
            end

`ifdef I2C_SLAVE_READ_EN
            READ: begin
               if (scl_rise && !byte_full) begin
                  bit_cnt <= bit_cnt + 4'd1;
               end else if (scl_fall) begin
                  if (byte_full) begin
                     sda_low <= 1'b0;
                  end else begin
                     shift_reg <= {shift_reg[6:0], 1'b0};
                     sda_low   <= ~shift_reg[6];
                  end
               end
            end

            READ_ACK: begin
               if (scl_rise) begin
                  ack <= ~sda_sync;
               end else if (scl_fall) begin
                  if (ack) begin
                     ptr       <= next_ptr;
                     shift_reg <= rd_next;
                     sda_low   <= ~rd_next[7];
                     bit_cnt   <= 4'd0;
                  end else begin
                     sda_low <= 1'b0;
                  end
               end
            end
`endif

            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_slave.sv
//------------------------------------------------------------------------------
// tb_i2c_slave
//
// Directed bench for i2c_slave.  A bit-banged master drives scl/sda with an
// open-drain model and a pull-up.  A transaction-level model tracks what the
// three registers must hold and which bytes must be acknowledged; one compare
// process checks the register outputs against it every clock, and literal
// expectations after key transactions pin the model itself.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_i2c_slave;

   localparam int         Q          = 100;
   localparam logic [6:0] SLAVE_ADDR = 7'h55;

   typedef logic [7:0] byte_q_t[$];

   logic       clk       = 1'b0;
   logic       reset     = 1'b0;
   logic       scl       = 1'b1;
   logic       m_sda_low = 1'b0;
   logic       check_en  = 1'b1;
   wire        sda;
   logic [7:0] wave;
   logic [7:0] frequency;
   logic [7:0] duty_cycle;

   logic [7:0] m_regs [3];
   int         m_ptr    = 0;
   int         n_checks = 0;
   int         n_fail   = 0;

   pullup (sda);
   assign sda = m_sda_low ? 1'b0 : 1'bz;

   i2c_slave #(.SLAVE_ADDR(SLAVE_ADDR)) dut (
      .clk        (clk),
      .reset      (reset),
      .scl        (scl),
      .sda        (sda),
      .wave       (wave),
      .frequency  (frequency),
      .duty_cycle (duty_cycle)
   );

   // 100 MHz system clock; bus events sit 3 ns off the clock grid.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string name, input logic [7:0] actual,
                              input logic [7:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%02h, expected 0x%02h", name, actual, expected);
      end
   endtask

   // Register outputs must match the model whenever no byte is being
   // committed; checked on the falling clock edge.
   initial begin
      forever begin
         @(negedge clk);
         if (check_en) begin
            checkOutput("model_wave", wave, m_regs[0]);
            checkOutput("model_frequency", frequency, m_regs[1]);
            checkOutput("model_duty_cycle", duty_cycle, m_regs[2]);
         end
      end
   end

   // One data bit: change sda while scl is low, then a full scl pulse.
   task automatic sendBit(input logic b);
      #Q; m_sda_low = !b;
      #Q; scl = 1'b1;
      #(2*Q); scl = 1'b0;
   endtask

   // START (or repeated START): bring both lines high, then sda falls
   // while scl is high.
   task automatic i2cStart();
      #Q; m_sda_low = 1'b0;
      #Q; scl = 1'b1;
      #Q; m_sda_low = 1'b1;
      #Q; scl = 1'b0;
   endtask

   // STOP: sda rises while scl is high; the slave must be off the line.
   task automatic i2cStop();
      #Q; m_sda_low = 1'b1;
      #Q; scl = 1'b1;
      #Q; m_sda_low = 1'b0;
      #Q;
      checkOutput("sda_after_stop", {7'd0, sda}, 8'h01);
   endtask

   // Eight bits MSB first plus the acknowledge slot, where the slave's
   // answer is sampled in the middle of the 9th scl high phase.
   task automatic sendByte(input logic [7:0] b, input logic exp_ack, input int idx);
      for (int i = 7; i >= 0; i--) begin
         if (i == 0) check_en = 1'b0;
         sendBit(b[i]);
      end
      #Q; m_sda_low = 1'b0;
      #Q; scl = 1'b1;
      #Q;
      checkOutput($sformatf("ack_byte%0d", idx), {7'd0, sda}, {7'd0, !exp_ack});
      #Q; scl = 1'b0;
   endtask

   task automatic partialBits(input logic [7:0] b, input int n);
      for (int i = 7; i > 7 - n; i--) begin
         sendBit(b[i]);
      end
   endtask

   // Full write transaction.  The model decides per byte whether the slave
   // is still listening and whether it must ACK, and applies data bytes to
   // the register image once they are complete.
   task automatic applyStimulus(input byte_q_t bytes, input bit with_stop);
      bit         live;
      logic [7:0] b;
      logic       exp_ack;
      i2cStart();
      live = 1'b1;
      foreach (bytes[i]) begin
         b = bytes[i];
         if (!live)       exp_ack = 1'b0;
         else if (i == 0) exp_ack = (b[7:1] == SLAVE_ADDR) && (b[0] == 1'b0);
         else if (i == 1) exp_ack = (b <= 8'h02);
         else             exp_ack = 1'b1;
         sendByte(b, exp_ack, i);
         if (live && i == 1 && exp_ack) m_ptr = int'(b);
         if (live && i >= 2) begin
            m_regs[m_ptr] = b;
            m_ptr = (m_ptr + 1) % 3;
         end
         live = live && exp_ack;
         check_en = 1'b1;
      end
      if (with_stop) i2cStop();
   endtask

   initial begin
      byte_q_t tx;
      m_regs = '{default: 8'h00};

      // Reset held for 100 ns, then released.
      #103;
      reset = 1'b1;
      #Q;
      checkOutput("reset_wave", wave, 8'h00);
      checkOutput("reset_frequency", frequency, 8'h00);
      checkOutput("reset_duty_cycle", duty_cycle, 8'h00);
      checkOutput("reset_sda", {7'd0, sda}, 8'h01);

      $display("[TB] address-only write");
      tx = '{8'hAA};
      applyStimulus(tx, 1);

      $display("[TB] single register write");
      tx = '{8'hAA, 8'h01, 8'h02};
      applyStimulus(tx, 1);
      checkOutput("t3_wave", wave, 8'h00);
      checkOutput("t3_frequency", frequency, 8'h02);
      checkOutput("t3_duty_cycle", duty_cycle, 8'h00);

      $display("[TB] burst write with pointer wrap");
      tx = '{8'hAA, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
      applyStimulus(tx, 1);
      checkOutput("t4_wave", wave, 8'h44);
      checkOutput("t4_frequency", frequency, 8'h22);
      checkOutput("t4_duty_cycle", duty_cycle, 8'h33);

      $display("[TB] wrong address, bad pointer, read request");
      tx = '{8'hA8, 8'h00, 8'h99};
      applyStimulus(tx, 1);
      tx = '{8'hAA, 8'h05, 8'h77};
      applyStimulus(tx, 1);
      tx = '{8'hAB};
      applyStimulus(tx, 1);

      $display("[TB] repeated START");
      tx = '{8'hAA, 8'h02};
      applyStimulus(tx, 0);
      tx = '{8'hAA, 8'h01, 8'h66};
      applyStimulus(tx, 1);
      checkOutput("t8_wave", wave, 8'h44);
      checkOutput("t8_frequency", frequency, 8'h66);
      checkOutput("t8_duty_cycle", duty_cycle, 8'h33);

      $display("[TB] partial byte then STOP");
      tx = '{8'hAA, 8'h00};
      applyStimulus(tx, 0);
      partialBits(8'hFF, 4);
      i2cStop();

      $display("[TB] write starting at last register");
      tx = '{8'hAA, 8'h02, 8'hD1, 8'hD2};
      applyStimulus(tx, 1);
      checkOutput("t10_wave", wave, 8'hD2);
      checkOutput("t10_frequency", frequency, 8'h66);
      checkOutput("t10_duty_cycle", duty_cycle, 8'hD1);

      $display("[TB] reset during 4th data bit");
      tx = '{8'hAA, 8'h00};
      applyStimulus(tx, 0);
      partialBits(8'hF0, 3);
      #Q; m_sda_low = 1'b0;
      #Q; scl = 1'b1;
      #Q;
      reset = 1'b0;
      m_regs = '{default: 8'h00};
      m_ptr = 0;
      #100;
      checkOutput("rst_mid_wave", wave, 8'h00);
      checkOutput("rst_mid_frequency", frequency, 8'h00);
      checkOutput("rst_mid_duty_cycle", duty_cycle, 8'h00);
      checkOutput("rst_mid_sda", {7'd0, sda}, 8'h01);
      reset = 1'b1;
      #Q;
      tx = '{8'hAA, 8'h00, 8'h5A, 8'hA5, 8'hC3};
      applyStimulus(tx, 1);
      checkOutput("t11_wave", wave, 8'h5A);
      checkOutput("t11_frequency", frequency, 8'hA5);
      checkOutput("t11_duty_cycle", duty_cycle, 8'hC3);

      #Q;
      $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 7'h55, giving the 7-bit I2C device address.
REQ-002 SHALL have port clk, input, 1 bit: single system clock; all logic is on the rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset (0 = reset).
REQ-004 SHALL have port scl, input, 1 bit: I2C clock from the master; the slave never drives it.
REQ-005 SHALL have port sda, inout, 1 bit: I2C data, open-drain; the slave drives only 0 or z.
REQ-006 SHALL have port wave, output, 8 bits: waveform-select register, address 0x00.
REQ-007 SHALL have port frequency, output, 8 bits: frequency register, address 0x01.
REQ-008 SHALL have port duty_cycle, output, 8 bits: duty-cycle register, address 0x02.

Function
REQ-009 SHALL synchronise scl and sda through 2 flip-flops each, then detect edges on the synchronised versions; requires clk >= 10x the SCL rate.
REQ-010 SHALL detect START as a falling edge of sda while scl is high, and STOP as a rising edge of sda while scl is high.
REQ-011 SHALL sample data bits on the scl rising edge, MSB first, and change its sda drive only after an scl falling edge.
REQ-012 SHALL implement these FSM states: IDLE, ADDR, ADDR_ACK, REG, REG_ACK, DATA, DATA_ACK, WAIT_STOP, plus the read states of REQ-027.
REQ-013 SHALL move from any state to ADDR on START, including a repeated START, and clear the bit counter.
REQ-014 SHALL move from any state to IDLE on STOP and release sda.
REQ-015 SHALL compare the first byte after START, bits [7:1], with SLAVE_ADDR; bit [0] is R/W.
REQ-016 SHALL, on an address match with R/W=0, drive sda low from the 8th scl falling edge to the 9th scl falling edge (ACK), then enter REG.
REQ-017 SHALL, on an address mismatch, leave sda released (NACK) and enter WAIT_STOP; WAIT_STOP ignores bus traffic until START or STOP.
REQ-018 SHALL latch the byte received in REG as the register pointer; it ACKs the pointer if it is 0x00 to 0x02, else NACKs it and enters WAIT_STOP.
REQ-019 SHALL, for each DATA byte, ACK it and write it to the pointed register on the 8th scl rising edge.
REQ-020 SHALL update the output registers only on a completed 8-bit byte; a START or STOP mid-byte discards the partial byte.
REQ-021 SHALL auto-increment the pointer after each data byte, wrapping from 0x02 to 0x00.
REQ-022 SHALL not change the outputs between writes; each output holds its last written value.

Reset
REQ-023 SHALL, while reset=0, immediately set wave, frequency and duty_cycle to 8'h00.
REQ-024 SHALL, while reset=0, set the FSM to IDLE, the pointer and counters to 0, the synchronisers to 1, and release sda (z).
REQ-025 SHALL, when reset is asserted mid-transfer, abort the transfer; after release the slave waits for a new START.

Configuration
REQ-026 SHALL, with macro I2C_SLAVE_READ_EN undefined, NACK an address match with R/W=1 and enter WAIT_STOP.
REQ-027 SHALL, with I2C_SLAVE_READ_EN defined, ACK a read; states READ and READ_ACK shift out the pointed register MSB first (drive 0 for a 0 bit, z for a 1 bit).
REQ-028 SHALL, in read mode with I2C_SLAVE_READ_EN defined, auto-increment the pointer (wrapping) on a master ACK and, on a master NACK, enter WAIT_STOP with sda released.

Verification
REQ-029 SHALL pass: reset=0 for 100 ns, then release -> all outputs 0x00 and sda = z.
REQ-030 SHALL pass: START, address byte 0xAA (address 0x55, write) -> sda=0 during the 9th scl pulse; STOP -> sda = z and outputs unchanged.
REQ-031 SHALL pass: START, 0xAA, 0x01, 0x02, STOP -> frequency=0x02 and the other outputs unchanged.
REQ-032 SHALL pass: START, 0xAA, 0x00, 0x11, 0x22, 0x33, 0x44, STOP -> wave=0x44, frequency=0x22, duty_cycle=0x33.
REQ-033 SHALL pass: START, 0xA8 (address 0x54) -> no ACK and subsequent bytes ignored; START, 0xAA, 0x05 -> pointer NACKed and no register changed.
REQ-034 SHALL pass: reset asserted during the 4th data bit -> outputs 0x00 and FSM IDLE; the next full write succeeds.
